// File: rtl/multiword_add_pkg.sv
// -----------------------------------------------------------------------------
// multiword_add_pkg
// Shared types and helpers for the multi-word adder sequencer.
//   state_t   : sequencer FSM encoding (IDLE, CALC, DONE), 2 bits wide.
//   idx_width : width of the chunk index register, never below 1 bit.
// -----------------------------------------------------------------------------
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage : multiword_add_pkg

// File: rtl/multiword_add_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Purely combinational nbits-wide adder with carry in and carry out.
// The addition is done at nbits+1 bits on zero-extended operands, so the
// carry out is never lost.
// Ports:
//   a, b  : nbits operands
//   cin   : carry in
//   s     : nbits sum
//   cout  : carry out
// -----------------------------------------------------------------------------
module chunk_adder #(
  parameter int nbits = 8
) (
  input  logic [nbits-1:0] a,
  input  logic [nbits-1:0] b,
  input  logic             cin,
  output logic [nbits-1:0] s,
  output logic             cout
);

  logic [nbits:0] full_sum_s;

  assign full_sum_s = {1'b0, a} + {1'b0, b} + {{nbits{1'b0}}, cin};
  assign s          = full_sum_s[nbits-1:0];
  assign cout       = full_sum_s[nbits];

endmodule : chunk_adder

// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
// Multi-word adder sequencer. Wide operands are accepted over a val/rdy
// handshake, added one nbits chunk per cycle (least significant first) with
// the carry fed back between chunks, and the assembled wide sum is offered
// over a second val/rdy handshake.
//
// Parameters:
//   nbits   : chunk width (>= 1)
//   nchunks : chunks per operand (>= 1); W = nbits*nchunks
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous reset, active low
//   in_val   : operands valid          in_rdy   : ready for operands (IDLE)
//   in_a     : operand A (W)           in_b     : operand B (W)
//   in_cin   : carry into chunk 0
//   out_val  : result valid (DONE)     out_rdy  : consumer takes result
//   out_sum  : (in_a + in_b + in_cin) mod 2^W, registered
//   out_cout : carry out of the top chunk, registered
//   out_ovf  : signed overflow, only when MULTIWORD_ADD_SEQ_OVF_EN is defined
//
// Build option: MULTIWORD_ADD_SEQ_OVF_EN adds out_ovf and its register.
// -----------------------------------------------------------------------------
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int nbits   = 8,
  parameter int nchunks = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [nbits*nchunks-1:0] in_a,
  input  logic [nbits*nchunks-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [nbits*nchunks-1:0] out_sum,
  output logic                     out_cout
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  ,
  output logic                     out_ovf
`endif
);

  localparam int W  = nbits * nchunks;
  localparam int IW = idx_width(nchunks);
  localparam logic [IW-1:0] LAST_IDX = IW'(nchunks - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
  logic            msb_cin_s;
`endif

  logic [31:0]      base_s;
  logic [nbits-1:0] ch_a_s;
  logic [nbits-1:0] ch_b_s;
  logic [nbits-1:0] ch_s_s;
  logic             ch_cout_s;

  // Bit offset of the chunk currently being worked on.
  assign base_s = 32'(idx_q) * 32'(nbits);
  assign ch_a_s = a_q[base_s +: nbits];
  assign ch_b_s = b_q[base_s +: nbits];

  // Single shared chunk adder; operands are muxed by idx_q.
  chunk_adder #(
    .nbits (nbits)
  ) u_chunk_adder (
    .a    (ch_a_s),
    .b    (ch_b_s),
    .cin  (carry_q),
    .s    (ch_s_s),
    .cout (ch_cout_s)
  );

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  // Carry into the chunk MSB recovered from the sum bit: s = a ^ b ^ c.
  assign msb_cin_s = ch_s_s[nbits-1] ^ ch_a_s[nbits-1] ^ ch_b_s[nbits-1];
`endif

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_val) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = {IW{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        sum_d[base_s +: nbits] = ch_s_s;
        carry_d                = ch_cout_s;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
          ovf_d   = msb_cin_s ^ ch_cout_s;
`endif
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        // Unused encoding falls back to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, sum and carry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      carry_q <= 1'b0;
      idx_q   <= {IW{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  // Signed overflow flag captured on the final chunk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

  // Handshake flags depend on the state register alone.
  assign in_rdy   = (state_q == IDLE);
  assign out_val  = (state_q == DONE);
  assign out_sum  = sum_q;
  assign out_cout = carry_q;

endmodule : multiword_add_seq

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

  localparam int NB = 8;
  localparam int NC = 4;
  localparam int W  = NB * NC;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_val;
  logic         in_rdy;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_val;
  logic         out_rdy;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  logic         out_ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(
    .nbits   (NB),
    .nchunks (NC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_sum  (out_sum),
    .out_cout (out_cout)
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  // Reference arithmetic: full-width add plus sign-rule overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] t;
    exp_t e;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  // Present one operand set in IDLE; returns #1 after the accepting edge.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    in_a   = a;
    in_b   = b;
    in_cin = cin;
    in_val = 1'b1;
    sb_q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  // Count edges until out_val is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (out_val === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Complete the output handshake on the next edge.
  task automatic take_out();
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_cin  = 1'b0;
    #12;
    n_checks++; if (in_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    n_checks++; if (out_val !== 1'b0) begin n_errors++; $display("FAIL reset_out_val got %b want 0", out_val); end
    n_checks++; if (out_sum !== 32'h0) begin n_errors++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_errors++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    n_checks++; if (out_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int   lat;
    exp_t e;
    send_op(a, b, cin);
    wait_out(lat);
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL %s_latency got %0d want 4", name, lat); end
    e = sb_q.pop_front();
    n_checks++; if (out_sum !== e.sum) begin n_errors++; $display("FAIL %s_sum got %h want %h", name, out_sum, e.sum); end
    n_checks++; if (out_cout !== e.cout) begin n_errors++; $display("FAIL %s_cout got %b want %b", name, out_cout, e.cout); end
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    n_checks++; if (out_ovf !== e.ovf) begin n_errors++; $display("FAIL %s_ovf got %b want %b", name, out_ovf, e.ovf); end
`endif
    take_out();
    n_checks++; if (in_rdy !== 1'b1) begin n_errors++; $display("FAIL %s_idle got %b want 1", name, in_rdy); end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    send_op(32'h12345678, 32'h11111111, 1'b0);
    wait_out(lat);
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_val !== 1'b1) begin n_errors++; $display("FAIL bp_out_val[%0d] got %b want 1", i, out_val); end
      n_checks++; if (out_sum !== e.sum) begin n_errors++; $display("FAIL bp_sum[%0d] got %h want %h", i, out_sum, e.sum); end
      n_checks++; if (in_rdy !== 1'b0) begin n_errors++; $display("FAIL bp_in_rdy[%0d] got %b want 0", i, in_rdy); end
      @(negedge clk);
      in_val = 1'b1;
      in_a   = $urandom;
      in_b   = $urandom;
      @(posedge clk);
      #1;
      in_val = 1'b0;
    end
    n_checks++; if (out_sum !== e.sum) begin n_errors++; $display("FAIL bp_sum_end got %h want %h", out_sum, e.sum); end
    take_out();
    n_checks++; if (in_rdy !== 1'b1) begin n_errors++; $display("FAIL bp_idle got %b want 1", in_rdy); end
    @(posedge clk);
    #1;
    n_checks++; if (in_rdy !== 1'b1 || out_val !== 1'b0) begin n_errors++; $display("FAIL bp_no_accept got rdy=%b val=%b want rdy=1 val=0", in_rdy, out_val); end
  endtask

  task automatic test_reset_midop();
    send_op(32'hFFFFFFFF, 32'h00000001, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (out_val !== 1'b0) begin n_errors++; $display("FAIL midrst_out_val got %b want 0", out_val); end
    n_checks++; if (in_rdy !== 1'b1) begin n_errors++; $display("FAIL midrst_in_rdy got %b want 1", in_rdy); end
    void'(sb_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    test_single("midrst_after", 32'h00000001, 32'h00000001, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   o1, idle_n, acc2, o2;
    exp_t e;
    o1 = -1; idle_n = -1; acc2 = -1; o2 = -1;
    @(negedge clk);
    in_a    = 32'hA5A5A5A5;
    in_b    = 32'h5A5A5A5B;
    in_cin  = 1'b0;
    in_val  = 1'b1;
    out_rdy = 1'b1;
    sb_q.push_back(model(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0));
    @(posedge clk);
    #1;
    in_a   = 32'h0F0F0F0F;
    in_b   = 32'hF0F0F0F0;
    in_cin = 1'b1;
    sb_q.push_back(model(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1));
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (o1 < 0 && out_val === 1'b1) begin
        o1 = n;
        e  = sb_q.pop_front();
        n_checks++; if (out_sum !== e.sum || out_cout !== e.cout) begin n_errors++; $display("FAIL b2b_first got %h/%b want %h/%b", out_sum, out_cout, e.sum, e.cout); end
      end else if (o1 >= 0 && idle_n < 0 && in_rdy === 1'b1) begin
        idle_n = n;
      end else if (idle_n >= 0 && acc2 < 0 && in_rdy === 1'b0) begin
        acc2   = n;
        in_val = 1'b0;
      end else if (acc2 >= 0 && out_val === 1'b1) begin
        o2 = n;
        e  = sb_q.pop_front();
        n_checks++; if (out_sum !== e.sum || out_cout !== e.cout) begin n_errors++; $display("FAIL b2b_second got %h/%b want %h/%b", out_sum, out_cout, e.sum, e.cout); end
        break;
      end
    end
    in_val = 1'b0;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    n_checks++; if (o1 !== 4) begin n_errors++; $display("FAIL b2b_o1 got %0d want 4", o1); end
    n_checks++; if (idle_n !== 5) begin n_errors++; $display("FAIL b2b_idle got %0d want 5", idle_n); end
    n_checks++; if (acc2 !== 6) begin n_errors++; $display("FAIL b2b_accept2 got %0d want 6", acc2); end
    n_checks++; if (o2 !== 10) begin n_errors++; $display("FAIL b2b_o2 got %0d want 10", o2); end
    n_checks++; if (in_rdy !== 1'b1) begin n_errors++; $display("FAIL b2b_idle_end got %b want 1", in_rdy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_single("random", $urandom, $urandom, 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_single("ripple", 32'h000000FF, 32'h00000001, 1'b0);
    test_single("wrap", 32'hFFFFFFFF, 32'h00000000, 1'b1);
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_single("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0);
    test_single("ovf_neg", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    test_single("ovf_mixed", 32'h80000000, 32'h80000000, 1'b0);
    test_random();
    n_checks++; if (sb_q.size() !== 0) begin n_errors++; $display("FAIL scoreboard_empty got %0d want 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_multiword_add_seq

// File: doc/multiword_add_seq.md
# multiword_add_seq

Multi-word adder sequencer that sits on both sides of the single-chunk carry adder. It accepts wide operands over a val/rdy handshake and slices them into nbits chunks, least significant first. Each chunk's carry-out is fed back as the next chunk's carry-in, and the registered result words are assembled into a wide sum delivered over a second val/rdy handshake. It lets the narrow adder datapath serve operand widths of nbits*nchunks at one chunk per cycle.

## Interface
Parameters:
- nbits, 8, chunk width in bits; ≥1.
- nchunks, 4, chunks per operand; ≥1. Total width W = nbits*nchunks.

Ports:
- clk  input  1  clock. All state changes on the rising edge.
- reset  input  1  reset. Asynchronous and active-low: asserted when 0.
- in_val  input  1  operands valid.
- in_rdy  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry into chunk 0.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts the result.
- out_sum  output  W  (in_a + in_b + in_cin) mod 2^W.
- out_cout  output  1  carry out of the most significant chunk.
- out_ovf  output  1  signed overflow. Present only with MULTIWORD_ADD_SEQ_OVF_EN.

## Operation
The FSM has three states: IDLE, CALC and DONE. Registers: a_q, b_q, sum_q (all W bits), carry_q, and idx_q (clog2(nchunks) bits, minimum 1).

- **IDLE**
  - in_rdy=1, out_val=0.
  - On in_val=1: latch a_q=in_a, b_q=in_b, carry_q=in_cin, idx_q=0, then go to CALC.
- **CALC**
  - in_rdy=0, out_val=0.
  - Each cycle computes {c, s} = a_q[idx] + b_q[idx] + carry_q, where [idx] is chunk bits idx*nbits +: nbits.
  - Writes sum_q[idx]=s and carry_q=c.
  - If idx_q == nchunks-1, go to DONE; otherwise idx_q+1.
  - Exactly nchunks CALC cycles. With nchunks=1 there is one CALC cycle.
- **DONE**
  - out_val=1, out_sum=sum_q, out_cout=carry_q.
  - On out_rdy=1, go to IDLE.
  - in_rdy=0, so no operand is accepted in DONE.
- in_val is ignored outside IDLE. in_a, in_b and in_cin are sampled only on the accepting edge.
- Arithmetic is unsigned, modulo 2^W. Chunk arithmetic uses a zero-extended nbits+1 sum, so the carry is never truncated.
- The unused state encoding recovers to IDLE.

## Timing
- **Reset values** (asynchronous, all outputs): state=IDLE, in_rdy=1, out_val=0, out_sum=0, out_cout=0, out_ovf=0, idx_q=0, carry_q=0.
- **Reset mid-operation** (CALC or DONE): the operation is aborted and the result is discarded. The block is in IDLE on the first edge after reset deasserts.
- **Latency**: operands accepted on edge E. out_val=1 after edge E+nchunks.
- **Throughput**: one operation per nchunks+2 cycles. One cycle is spent in IDLE between operations.
- in_rdy and out_val are decoded from state only, with no combinational path from in_val or out_rdy.
- out_sum and out_cout are registered. They hold stable while out_val=1 and out_rdy=0, with unlimited backpressure.
- An output handshake and a new in_val in the same cycle do not interact: the new operand is accepted in the following IDLE cycle.

## Configuration
- Macro: MULTIWORD_ADD_SEQ_OVF_EN.
- **Defined**:
  - out_ovf port exists.
  - An extra register captures the carry into the MSB of the top chunk during the final CALC cycle.
  - out_ovf = that carry XOR out_cout, valid with out_val and held under backpressure.
- **Undefined**: the out_ovf port and the extra register are absent. All other behaviour is identical.

## Structure
- **Package multiword_add_pkg**:
  - typedef enum state_t {IDLE, CALC, DONE}, 2-bit.
  - Index-width helper function.
- **Sub-module chunk_adder**:
  - Combinational; parameter nbits; inputs a, b, cin; outputs s, cout.
  - Instantiated once and shared across chunks by idx_q muxing.
- The top level holds the FSM, operand and sum registers, and the carry feedback.

## Test plan
All scenarios use nbits=8, nchunks=4.
- **Carry ripple**: A=0x000000FF, B=0x00000001, cin=0 → sum=0x00000100, cout=0, out_val asserted 4 edges after acceptance.
- **Full wrap**: A=0xFFFFFFFF, B=0x00000000, cin=1 → sum=0x00000000, cout=1.
- **Backpressure**:
  - Stimulus: A=0x12345678, B=0x11111111, out_rdy=0 for 5 cycles in DONE.
  - Response: out_val stays 1, sum=0x23456789 stable, in_rdy=0, in_val pulses ignored.
  - IDLE is entered the edge after out_rdy=1.
- **Reset mid-op**: reset=0 while in CALC with idx_q=2 → out_val=0 and in_rdy=1 immediately. After release, 0x00000001+0x00000001 gives sum=0x00000002, with no stale carry.
- **Back-to-back**: in_val held at 1 with two operand sets → second operand accepted exactly one cycle after the first output handshake. Period = 6 cycles.
- **Overflow (OVF_EN)**:
  - Macro defined: A=0x7FFFFFFF, B=0x00000001 → sum=0x80000000, ovf=1, cout=0. A=0xFFFFFFFF, B=0x00000001 → ovf=0, cout=1.
  - Macro undefined: the build elaborates without out_ovf.
